// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts one load/store on a valid/ready request
// channel, performs it on a byte-strobed word array and answers on a valid/ready response channel.
module data_mem_responder #(
    parameter int DEPTH    = 128,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (READ_LAT < 2) ? 1 : $clog2(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rspErr_q, rspErr_d;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                reqErr;
    logic [ADDR_W-1:0]   reqIdx;
    logic [ADDR_W-1:0]   rdIdx;
    logic [31:0]         rdWord;
    logic                memWe;

    assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));
    assign reqIdx = req_addr[ADDR_W+1:2];
    assign accept = req_valid && (state_q == S_IDLE);
    assign memWe  = accept && req_we && !reqErr;

    // In IDLE the read port looks at the incoming request so READ_LAT==1 can respond directly.
    assign rdIdx  = (state_q == S_IDLE) ? reqIdx : idx_q;
    assign rdWord = mem_q[rdIdx];

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rspErr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rspErr_d = rspErr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = reqIdx;
                    err_d = reqErr;
                    if (req_we) begin
                        state_d  = S_RESP;
                        rdata_d  = 32'h0;
                        rspErr_d = reqErr;
                    end else if (READ_LAT == 1) begin
                        state_d  = S_RESP;
                        rdata_d  = reqErr ? 32'h0 : rdWord;
                        rspErr_d = reqErr;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_RESP;
                    rdata_d  = err_q ? 32'h0 : rdWord;
                    rspErr_d = err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d  = S_IDLE;
                    rdata_d  = 32'h0;
                    rspErr_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            rspErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rspErr_q <= rspErr_d;
        end
    end

    // Reset preloads each word with its own index; stores commit on the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'(i);
            end
        end else if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[reqIdx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
